// File: rtl/flash_playback_sequencer.sv
// Streams 16-bit audio samples out of a 32-bit Avalon-MM flash image.
// Each flash word holds two samples. The word is fetched on one sample tick
// and split across that tick and the next. The address then steps forward or
// backward and wraps at the ends of the image.
// Optional build macro FLASH_TIMEOUT_EN adds a readdatavalid watchdog that
// sets the sticky flag flash_timeout.
module flash_playback_sequencer #(
  parameter logic [22:0] END_ADDR    = 23'h7FFFF,
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_tick,
  input  logic        play_en,
  input  logic        dir,
  input  logic        restart,
  output logic        flash_mem_read,
  input  logic        flash_mem_waitrequest,
  output logic [22:0] flash_mem_address,
  output logic [3:0]  flash_mem_byteenable,
  input  logic [31:0] flash_mem_readdata,
  input  logic        flash_mem_readdatavalid,
  output logic [15:0] audio_sample,
  output logic        sample_valid,
  output logic        read_finished,
  output logic        flash_timeout
);

  localparam int unsigned AW = 23;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_TICK1,
    S_REQ,
    S_WAIT_DATA,
    S_WAIT_TICK2,
    S_ADVANCE
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [AW-1:0]   r_addr, w_addr_nxt;
  logic            r_read, w_read_nxt;
  logic [SW-1:0]   r_sample, w_sample_nxt;
  logic            r_svalid, w_svalid_nxt;
  logic            r_rfin, w_rfin_nxt;
  logic [DW-1:0]   r_word, w_word_nxt;
  logic            r_word_dir, w_word_dir_nxt;
  logic            r_pend, w_pend_nxt;
  logic            w_tick;
  logic            w_jump;

`ifdef FLASH_TIMEOUT_EN
  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_tmo, w_tmo_nxt;
`endif

  assign w_tick = sample_tick & play_en;
  // A restart arriving in the ADVANCE cycle itself still wins over the step.
  assign w_jump = r_pend | restart;

  // Next-state and next-register values
  always_comb begin
    w_state_nxt    = r_state;
    w_addr_nxt     = r_addr;
    w_sample_nxt   = r_sample;
    w_svalid_nxt   = 1'b0;
    w_rfin_nxt     = 1'b0;
    w_word_nxt     = r_word;
    w_word_dir_nxt = r_word_dir;
    w_pend_nxt     = r_pend | restart;
`ifdef FLASH_TIMEOUT_EN
    w_cnt_nxt      = '0;
    w_tmo_nxt      = r_tmo;
`endif

    case (r_state)
      S_IDLE: w_state_nxt = S_WAIT_TICK1;

      S_WAIT_TICK1: begin
        if (w_tick) w_state_nxt = S_REQ;
      end

      S_REQ: begin
        if (r_read && !flash_mem_waitrequest) w_state_nxt = S_WAIT_DATA;
      end

      S_WAIT_DATA: begin
        if (flash_mem_readdatavalid) begin
          w_word_nxt     = flash_mem_readdata;
          w_word_dir_nxt = dir;
          w_sample_nxt   = dir ? flash_mem_readdata[15:0] : flash_mem_readdata[31:16];
          w_svalid_nxt   = 1'b1;
          w_rfin_nxt     = 1'b1;
          w_state_nxt    = S_WAIT_TICK2;
        end
`ifdef FLASH_TIMEOUT_EN
        else if (r_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          w_tmo_nxt    = 1'b1;
          w_sample_nxt = '0;
          w_svalid_nxt = 1'b1;
          w_state_nxt  = S_ADVANCE;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
`endif
      end

      // Second half uses the direction captured with the word.
      S_WAIT_TICK2: begin
        if (w_tick) begin
          w_sample_nxt = r_word_dir ? r_word[31:16] : r_word[15:0];
          w_svalid_nxt = 1'b1;
          w_state_nxt  = S_ADVANCE;
        end
      end

      S_ADVANCE: begin
        w_pend_nxt  = 1'b0;
        w_state_nxt = S_WAIT_TICK1;
        if (w_jump) begin
          w_addr_nxt = dir ? '0 : END_ADDR;
        end else if (dir) begin
          w_addr_nxt = (r_addr == END_ADDR) ? '0 : r_addr + AW'(1);
        end else begin
          w_addr_nxt = (r_addr == '0) ? END_ADDR : r_addr - AW'(1);
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase

    // The read strobe is high for exactly the cycles spent in REQ.
    w_read_nxt = (w_state_nxt == S_REQ);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_read     <= 1'b0;
      r_sample   <= '0;
      r_svalid   <= 1'b0;
      r_rfin     <= 1'b0;
      r_word     <= '0;
      r_word_dir <= 1'b0;
      r_pend     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_addr     <= w_addr_nxt;
      r_read     <= w_read_nxt;
      r_sample   <= w_sample_nxt;
      r_svalid   <= w_svalid_nxt;
      r_rfin     <= w_rfin_nxt;
      r_word     <= w_word_nxt;
      r_word_dir <= w_word_dir_nxt;
      r_pend     <= w_pend_nxt;
    end
  end

`ifdef FLASH_TIMEOUT_EN
  // Watchdog counter and sticky timeout flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt <= '0;
      r_tmo <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      r_tmo <= w_tmo_nxt;
    end
  end

  assign flash_timeout = r_tmo;
`else
  // TIMEOUT_CYC stays on the interface so both builds share one parameter list.
  if (TIMEOUT_CYC == 0) begin : g_tmo_param_unused
  end

  assign flash_timeout = 1'b0;
`endif

  assign flash_mem_read       = r_read;
  assign flash_mem_address    = r_addr;
  assign flash_mem_byteenable = 4'hF;
  assign audio_sample         = r_sample;
  assign sample_valid         = r_svalid;
  assign read_finished        = r_rfin;

endmodule

// File: tb/tb_flash_playback_sequencer.sv
// Scoreboard bench for flash_playback_sequencer.
// Expected samples are queued when a word is requested and popped on sample_valid.
module tb_flash_playback_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_tick;
  logic        play_en;
  logic        dir;
  logic        restart;
  logic        flash_mem_read;
  logic        flash_mem_waitrequest;
  logic [22:0] flash_mem_address;
  logic [3:0]  flash_mem_byteenable;
  logic [31:0] flash_mem_readdata;
  logic        flash_mem_readdatavalid;
  logic [15:0] audio_sample;
  logic        sample_valid;
  logic        read_finished;
  logic        flash_timeout;

  int          n_chk = 0;
  int          n_err = 0;
  int          n_acc = 0;
  int          exp_reads = 0;
  int          n_unexp = 0;
  logic [15:0] sb[$];
  logic [15:0] mon_exp;

  flash_playback_sequencer dut (
    .clk                     (clk),
    .reset                   (reset),
    .sample_tick             (sample_tick),
    .play_en                 (play_en),
    .dir                     (dir),
    .restart                 (restart),
    .flash_mem_read          (flash_mem_read),
    .flash_mem_waitrequest   (flash_mem_waitrequest),
    .flash_mem_address       (flash_mem_address),
    .flash_mem_byteenable    (flash_mem_byteenable),
    .flash_mem_readdata      (flash_mem_readdata),
    .flash_mem_readdatavalid (flash_mem_readdatavalid),
    .audio_sample            (audio_sample),
    .sample_valid            (sample_valid),
    .read_finished           (read_finished),
    .flash_timeout           (flash_timeout)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Read-acceptance counter and sample scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (flash_mem_read && !flash_mem_waitrequest) n_acc++;
    if (sample_valid) begin
      if (sb.size() == 0) begin
        n_unexp++;
      end else begin
        mon_exp = sb.pop_front();
        chk("sample", 32'(audio_sample), 32'(mon_exp));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One full word: tick, request (with optional stalls), capture, second tick, advance.
  // rst_mask bit k pulses restart in phase k: 0 tick1, 1 capture, 2 tick2, 3 advance.
  task automatic fetch(input logic [22:0] exp_addr, input logic [31:0] data,
                       input int n_wait, input logic [3:0] rst_mask, input bit flip);
    logic [15:0] lo;
    logic [15:0] hi;
    lo = data[15:0];
    hi = data[31:16];
    sb.push_back(dir ? lo : hi);
    sb.push_back(dir ? hi : lo);
    exp_reads++;
    restart     = rst_mask[0];
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    restart     = 1'b0;
    flash_mem_waitrequest = (n_wait > 0);
    for (int i = 0; i < n_wait; i++) begin
      chk("wr_read", 32'(flash_mem_read), 32'd1);
      chk("wr_addr", 32'(flash_mem_address), 32'(exp_addr));
      step();
    end
    flash_mem_waitrequest = 1'b0;
    chk("rd_req", 32'(flash_mem_read), 32'd1);
    chk("rd_addr", 32'(flash_mem_address), 32'(exp_addr));
    step();
    chk("rd_drop", 32'(flash_mem_read), 32'd0);
    restart = rst_mask[1];
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata      = data;
    step();
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata      = 32'hFFFF_FFFF;
    restart = 1'b0;
    chk("rd_fin", 32'(read_finished), 32'd1);
    if (flip) dir = ~dir;
    restart     = rst_mask[2];
    sample_tick = 1'b1;
    step();
    sample_tick = 1'b0;
    restart     = rst_mask[3];
    step();
    restart = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    sample_tick = 1'b0;
    play_en = 1'b1;
    dir = 1'b1;
    restart = 1'b0;
    flash_mem_waitrequest = 1'b0;
    flash_mem_readdata = 32'hFFFF_FFFF;
    flash_mem_readdatavalid = 1'b0;
    step();
    step();
    chk("rst_addr", 32'(flash_mem_address), 32'd0);
    chk("rst_read", 32'(flash_mem_read), 32'd0);
    chk("rst_sample", 32'(audio_sample), 32'd0);
    chk("rst_sv", 32'(sample_valid), 32'd0);
    chk("rst_rfin", 32'(read_finished), 32'd0);
    chk("rst_tmo", 32'(flash_timeout), 32'd0);
    chk("byteen", 32'(flash_mem_byteenable), 32'hF);
    reset = 1'b0;
    step();
    step();

    // Forward fetch, zero-latency slave
    fetch(23'd0, 32'hBBBB_AAAA, 0, 4'b0000, 1'b0);
    chk("fwd_addr", 32'(flash_mem_address), 32'd1);
    chk("fwd_reads", 32'(n_acc), 32'(exp_reads));

    // Waitrequest stall for 5 cycles
    fetch(23'd1, 32'h1234_5678, 5, 4'b0000, 1'b0);
    chk("wr_next", 32'(flash_mem_address), 32'd2);
    chk("wr_reads", 32'(n_acc), 32'(exp_reads));

    // Pause: ticks ignored
    play_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      chk("pause_sv", 32'(sample_valid), 32'd0);
      chk("pause_smp", 32'(audio_sample), 32'h1234);
      chk("pause_rd", 32'(flash_mem_read), 32'd0);
      step();
    end
    play_en = 1'b1;

    // Double restart absorbed, forward restart to 0
    fetch(23'd2, 32'hCAFE_F00D, 0, 4'b0011, 1'b0);
    chk("rst_fwd", 32'(flash_mem_address), 32'd0);

    // Backward wrap 0 -> END_ADDR
    dir = 1'b0;
    fetch(23'd0, 32'h2222_1111, 0, 4'b0000, 1'b0);
    chk("bwd_wrap", 32'(flash_mem_address), 32'h7FFFF);

    // Forward wrap with restart pending in the same word
    dir = 1'b1;
    fetch(23'h7FFFF, 32'h0BAD_BEEF, 0, 4'b0100, 1'b0);
    chk("fwd_wrap", 32'(flash_mem_address), 32'd0);

    // Direction flip after capture: second half keeps captured order, step uses new dir
    fetch(23'd0, 32'h1357_2468, 0, 4'b0000, 1'b1);
    chk("flip_addr", 32'(flash_mem_address), 32'h7FFFF);
    chk("flip_dir", 32'(dir), 32'd0);

    fetch(23'h7FFFF, 32'h5555_4444, 0, 4'b0000, 1'b0);
    chk("bwd_step", 32'(flash_mem_address), 32'h7FFFE);

    // Restart in the ADVANCE cycle, backward -> END_ADDR
    fetch(23'h7FFFE, 32'h9999_8888, 0, 4'b1000, 1'b0);
    chk("rst_bwd", 32'(flash_mem_address), 32'h7FFFF);

    dir = 1'b1;
    fetch(23'h7FFFF, 32'h7777_6666, 2, 4'b0000, 1'b0);
    chk("fwd_wrap2", 32'(flash_mem_address), 32'd0);
    fetch(23'd0, 32'hA5A5_5A5A, 0, 4'b0001, 1'b0);
    chk("rst_at0", 32'(flash_mem_address), 32'd0);
    fetch(23'd0, 32'h0F0F_F0F0, 0, 4'b0000, 1'b0);
    chk("pend_clr", 32'(flash_mem_address), 32'd1);
    chk("mid_reads", 32'(n_acc), 32'(exp_reads));

    // Reset during WAIT_DATA with a restart pending, then a stale readdatavalid
    restart = 1'b1;
    sample_tick = 1'b1;
    step();
    restart = 1'b0;
    sample_tick = 1'b0;
    exp_reads++;
    step();
    #2;
    reset = 1'b1;
    #1;
    chk("ar_addr", 32'(flash_mem_address), 32'd0);
    chk("ar_read", 32'(flash_mem_read), 32'd0);
    chk("ar_sample", 32'(audio_sample), 32'd0);
    chk("ar_sv", 32'(sample_valid), 32'd0);
    chk("ar_rfin", 32'(read_finished), 32'd0);
    chk("ar_tmo", 32'(flash_timeout), 32'd0);
    flash_mem_readdatavalid = 1'b1;
    flash_mem_readdata = 32'hDEAD_BEEF;
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stale_rfin", 32'(read_finished), 32'd0);
      chk("stale_sv", 32'(sample_valid), 32'd0);
    end
    flash_mem_readdatavalid = 1'b0;
    flash_mem_readdata = 32'hFFFF_FFFF;
    fetch(23'd0, 32'h3C3C_C3C3, 0, 4'b0000, 1'b0);
    chk("post_rst", 32'(flash_mem_address), 32'd1);

`ifdef FLASH_TIMEOUT_EN
    // Watchdog: no readdatavalid
    begin
      bit seen;
      seen = 1'b0;
      sb.push_back(16'h0000);
      exp_reads++;
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      for (int i = 0; i < 600 && !seen; i++) begin
        step();
        if (flash_timeout) seen = 1'b1;
      end
      chk("tmo_seen", 32'(flash_timeout), 32'd1);
      chk("tmo_sample", 32'(audio_sample), 32'd0);
      step();
      chk("tmo_addr", 32'(flash_mem_address), 32'd2);
      step();
      chk("tmo_sticky", 32'(flash_timeout), 32'd1);
    end
`else
    chk("tmo_off", 32'(flash_timeout), 32'd0);
`endif

    step();
    step();
    chk("reads_total", 32'(n_acc), 32'(exp_reads));
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("unexp_sv", 32'(n_unexp), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
